// File: rtl/uart_tx_fifo.sv
// Byte FIFO and transmit sequencer that sits in front of uart_tx.
// Queued bytes go out one at a time: load tx_din, pulse tx_ena, then wait for a rising edge on tx_done.
//
// state | meaning
// IDLE  | nothing in flight; leaves as soon as the FIFO holds a byte
// LOAD  | pop the head byte into tx_din
// START | tx_ena high for this single cycle
// WAIT  | frame in progress; a rising edge on tx_done ends it
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          busy,
    output logic [7:0]    tx_din,
    output logic          tx_ena,
    input  logic          tx_done
);

    localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level_q;
    logic          done_q;
    logic          done_evt;
    logic          push;
    logic          pop;

    assign full     = (level_q == LEVEL_MAX);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign busy     = (state != IDLE);

    // A write while full is dropped even if a pop happens on the same edge.
    assign push     = wr_en & ~full;
    assign pop      = (state == LOAD);
    assign done_evt = tx_done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = START;
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_evt) begin
                    state_nxt = empty ? IDLE : LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level_q  <= '0;
            overflow <= 1'b0;
            tx_din   <= 8'h00;
            tx_ena   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= tx_done;
            tx_ena <= (state_nxt == START);
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                tx_din <= mem[rptr];
                rptr   <= rptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a vector table, hand-written overflow/reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          busy;
    logic [7:0]    tx_din;
    logic          tx_ena;
    logic          tx_done;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .tx_din   (tx_din),
        .tx_ena   (tx_ena),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_done;
        int         lvl;
        logic       emp;
        logic       ful;
        logic       bsy;
        logic       ena;
        logic [7:0] din;
        logic       ovf;
    } vec_t;

    function automatic vec_t mk(logic r, logic we, logic [7:0] wd, logic td, int lvl,
                                logic emp, logic ful, logic bsy, logic ena, logic [7:0] din, logic ovf);
        vec_t v;
        v.rst = r; v.wr_en = we; v.wr_data = wd; v.tx_done = td; v.lvl = lvl;
        v.emp = emp; v.ful = ful; v.bsy = bsy; v.ena = ena; v.din = din; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(string tag, int lvl, logic emp, logic ful, logic bsy,
                             logic ena, logic [7:0] din, logic ovf);
        chk({tag, ".level"},    32'(level),    32'(lvl));
        chk({tag, ".empty"},    32'(empty),    32'(emp));
        chk({tag, ".full"},     32'(full),     32'(ful));
        chk({tag, ".busy"},     32'(busy),     32'(bsy));
        chk({tag, ".tx_ena"},   32'(tx_ena),   32'(ena));
        chk({tag, ".tx_din"},   32'(tx_din),   32'(din));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    // Reference model: queue of accepted bytes plus the launch timeline
    // (-1 idle, 0 pop cycle, 1 strobe cycle, 2 waiting for done).
    logic [7:0] q[$];
    logic       m_ovf;
    logic [7:0] m_din;
    int         m_t;
    logic       m_prev;

    task automatic model_edge(logic r, logic we, logic [7:0] wd, logic td);
        logic evt;
        logic was_empty;
        logic was_full;
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_din  = 8'h00;
            m_t    = -1;
            m_prev = 1'b0;
            return;
        end
        evt       = td && !m_prev;
        m_prev    = td;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (m_t == 0) m_din = q.pop_front();
        if (we) begin
            if (was_full) m_ovf = 1'b1;
            else          q.push_back(wd);
        end
        case (m_t)
            -1:      m_t = was_empty ? -1 : 0;
            0:       m_t = 1;
            1:       m_t = 2;
            default: if (evt) m_t = was_empty ? -1 : 0;
        endcase
    endtask

    initial begin
        vec_t vt[$];
        int   rand_fail_prints;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;

        // ---- table: reset, single byte, burst with held done ----
        //           rst we data  td  lvl e  f  b  ena din    ovf
        vt.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0));
        vt.push_back(mk(0, 1, 8'h41, 0, 1, 0, 0, 0, 0, 8'h00, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h41, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h41, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h41, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h41, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h41, 0));
        vt.push_back(mk(0, 1, 8'h42, 0, 1, 0, 0, 0, 0, 8'h41, 0));
        vt.push_back(mk(0, 1, 8'h43, 0, 2, 0, 0, 1, 0, 8'h41, 0));
        vt.push_back(mk(0, 1, 8'h44, 0, 2, 0, 0, 1, 1, 8'h42, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 2, 0, 0, 1, 0, 8'h42, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 2, 0, 0, 1, 0, 8'h42, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 1, 8'h43, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h43, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h43, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h43, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h43, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h44, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 8'h44, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h44, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h44, 0));

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; wr_en = vt[i].wr_en; wr_data = vt[i].wr_data; tx_done = vt[i].tx_done;
            step();
            check_all($sformatf("vec%0d", i), vt[i].lvl, vt[i].emp, vt[i].ful, vt[i].bsy,
                      vt[i].ena, vt[i].din, vt[i].ovf);
        end

        // ---- overflow with tx_done stuck low: 18 pushes, last one dropped ----
        rst = 1'b1; wr_en = 1'b0; tx_done = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        step();
        check_all("ovf_stall", 16, 0, 1, 1, 0, 8'h00, 1);

        // ---- write at full on the pop edge is still dropped ----
        tx_done = 1'b1;
        step();
        chk("pop_edge.level_pre", 32'(level), 32'd16);
        tx_done = 1'b0; wr_en = 1'b1; wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        check_all("full_pop_write", 15, 0, 0, 1, 1, 8'h01, 1);
        step();

        // ---- drain: remaining bytes come out in order ----
        for (int i = 2; i <= 16; i++) begin
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            step();
            chk($sformatf("drain%0d.tx_ena", i), 32'(tx_ena), 32'd1);
            chk($sformatf("drain%0d.tx_din", i), 32'(tx_din), 32'(i));
            step();
        end
        check_all("drained", 0, 1, 0, 1, 0, 8'h10, 1);

        // ---- reset while waiting with five bytes queued ----
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'h60 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check_all("pre_reset", 5, 0, 0, 1, 0, 8'h10, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("mid_reset", 0, 1, 0, 0, 0, 8'h00, 0);
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        step();
        step();
        check_all("post_reset_tx", 0, 1, 0, 1, 1, 8'h55, 0);
        step();
        chk("post_reset_ena_once", 32'(tx_ena), 32'd0);

        // ---- randomized traffic against the reference model ----
        rand_fail_prints = 0;
        rst = 1'b1; wr_en = 1'b0; tx_done = 1'b0;
        model_edge(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 3000; c++) begin
            int wr_pct;
            int done_pct;
            logic ok;
            wr_pct   = (c < 1500) ? 50 : 25;
            done_pct = (c < 1500) ? 3 : 40;
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            wr_data = 8'($urandom());
            tx_done = ($urandom_range(0, 99) < done_pct);
            model_edge(rst, wr_en, wr_data, tx_done);
            step();
            ok = (32'(level) == q.size()) && (empty === (q.size() == 0)) &&
                 (full === (q.size() == DEPTH)) && (busy === (m_t >= 0)) &&
                 (tx_ena === (m_t == 1)) && (tx_din === m_din) && (overflow === m_ovf);
            total++;
            if (!ok) begin
                bad++;
                if (rand_fail_prints < 20) begin
                    rand_fail_prints++;
                    $display("FAIL rand cycle %0d: got lvl=%0d emp=%b ful=%b bsy=%b ena=%b din=%h ovf=%b expected lvl=%0d emp=%b ful=%b bsy=%b ena=%b din=%h ovf=%b",
                             c, level, empty, full, busy, tx_ena, tx_din, overflow,
                             q.size(), q.size() == 0, q.size() == DEPTH, m_t >= 0, m_t == 1, m_din, m_ovf);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
